uart_tx_buffer: RTL and testbench

Output end of the UART path. The write-back stage drives write_enable with a 32-bit data word. This block queues the low byte of each word in a small FIFO and serialises it on txd as 8N1 frames. It tells the pipeline to stall through tx_full, and records dropped bytes in a sticky overflow flag.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_tx_fifo.sv | 67 ++++++
 rtl/uart_tx_buffer.sv | 144 ++++++++++++++
 tb/tb_uart_tx_buffer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam logic        UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small circular FIFO feeding the UART serialiser; head entry is readable
// directly from storage while the FIFO is not empty.
module uart_tx_fifo #(
  parameter int unsigned FIFO_DEPTH_LOG = 2,
  parameter int unsigned WIDTH          = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full
);

  localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG;
  localparam logic [FIFO_DEPTH_LOG:0]   CNT_FULL = (FIFO_DEPTH_LOG + 1)'(DEPTH);
  localparam logic [FIFO_DEPTH_LOG:0]   CNT_ONE  = 1;
  localparam logic [FIFO_DEPTH_LOG-1:0] PTR_ONE  = 1;

  logic [WIDTH-1:0]          mem [DEPTH];
  logic [FIFO_DEPTH_LOG-1:0] wr_ptr;
  logic [FIFO_DEPTH_LOG-1:0] rd_ptr;
  logic [FIFO_DEPTH_LOG:0]   count;
  logic [FIFO_DEPTH_LOG:0]   count_next;
  logic                      do_push;
  logic                      do_pop;

  // Pushes are refused on the registered full flag, so a pop on the same
  // edge never makes room for a write presented while full.
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  // Occupancy after this edge; simultaneous push and pop leave it unchanged.
  always_comb begin
    count_next = count;
    unique case ({do_push, do_pop})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase
  end

  // Pointer, occupancy and full-flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_next;
      full  <= (count_next == CNT_FULL);
    end
  end

  // Storage array; contents need no reset since they are only read when valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_buffer.sv
// Buffered 8N1 UART transmitter: queues the low byte of each write-back word
// and serialises it on txd, with stall and sticky overflow reporting.
module uart_tx_buffer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT   = 868,
  parameter int unsigned FIFO_DEPTH_LOG = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        write_enable,
  input  logic [31:0] data,
  output logic        tx_full,
  output logic        tx_busy,
  output logic        overflow,
  output logic        txd
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IW = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_ONE  = 1;
  localparam logic [IW-1:0] BIT_LAST  = IW'(UART_DATA_BITS - 1);
  localparam logic [IW-1:0] BIT_ONE   = 1;

  tx_state_t                 state,  state_n;
  logic [CW-1:0]             baud,   baud_n;
  logic [IW-1:0]             idx,    idx_n;
  logic [UART_DATA_BITS-1:0] shift,  shift_n;
  logic                      txd_n;
  logic                      pop;
  logic                      empty;
  logic                      baud_end;
  logic [UART_DATA_BITS-1:0] head;
  logic                      unused_upper;

  assign unused_upper = ^data[31:UART_DATA_BITS];
  assign baud_end     = (baud == BAUD_LAST);
  assign tx_busy      = (state != IDLE) || !empty;

  uart_tx_fifo #(
    .FIFO_DEPTH_LOG (FIFO_DEPTH_LOG),
    .WIDTH          (UART_DATA_BITS)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (write_enable),
    .push_data (data[UART_DATA_BITS-1:0]),
    .pop       (pop),
    .pop_data  (head),
    .empty     (empty),
    .full      (tx_full)
  );

  // Frame sequencing: next state, line level, baud/bit counters and FIFO pop.
  always_comb begin
    state_n = state;
    baud_n  = baud;
    idx_n   = idx;
    shift_n = shift;
    txd_n   = txd;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        txd_n  = UART_IDLE_LEVEL;
        baud_n = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_n = head;
          txd_n   = ~UART_IDLE_LEVEL;
          state_n = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_n  = '0;
          idx_n   = '0;
          txd_n   = shift[0];
          state_n = DATA;
        end else begin
          baud_n = baud + BAUD_ONE;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_n = '0;
          if (idx == BIT_LAST) begin
            txd_n   = UART_IDLE_LEVEL;
            state_n = STOP;
          end else begin
            // txd takes the bit that becomes shift[0] after this shift.
            shift_n = shift >> 1;
            txd_n   = shift[1];
            idx_n   = idx + BIT_ONE;
          end
        end else begin
          baud_n = baud + BAUD_ONE;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_n = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_n = head;
            txd_n   = ~UART_IDLE_LEVEL;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          baud_n = baud + BAUD_ONE;
        end
      end
    endcase
  end

  // FSM and datapath registers; reset aborts any frame and idles the line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      baud  <= '0;
      idx   <= '0;
      shift <= '0;
      txd   <= UART_IDLE_LEVEL;
    end else begin
      state <= state_n;
      baud  <= baud_n;
      idx   <= idx_n;
      shift <= shift_n;
      txd   <= txd_n;
    end
  end

  // Sticky record of writes dropped because the FIFO was full.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (write_enable && tx_full) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Self-checking bench for uart_tx_buffer with a queue-level reference model.
module tb_uart_tx_buffer;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DLOG  = 2;
  localparam int unsigned DEPTH = 1 << DLOG;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        write_enable = 1'b0;
  logic [31:0] data = '0;
  logic        tx_full, tx_busy, overflow, txd;

  int checks = 0;
  int errors = 0;

  uart_tx_buffer #(
    .CLKS_PER_BIT   (CPB),
    .FIFO_DEPTH_LOG (DLOG)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .write_enable (write_enable),
    .data         (data),
    .tx_full      (tx_full),
    .tx_busy      (tx_busy),
    .overflow     (overflow),
    .txd          (txd)
  );

  always #5 clk = ~clk;

  // Reference model: a byte queue plus a queue of future line levels.
  byte unsigned mq[$];
  bit           ml[$];
  bit           m_txd  = 1'b1;
  bit           m_busy = 1'b0;
  bit           m_ovf  = 1'b0;
  bit           m_full = 1'b0;
  bit           m_pre_full, m_took;
  byte unsigned m_b;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      ml.delete();
      m_txd = 1'b1; m_busy = 1'b0; m_ovf = 1'b0; m_full = 1'b0;
    end else begin
      m_pre_full = (mq.size() == DEPTH);
      if (write_enable && m_pre_full) m_ovf = 1'b1;
      if (ml.size() == 0 && mq.size() != 0) begin
        m_b = mq.pop_front();
        for (int unsigned c = 0; c < CPB; c++) ml.push_back(1'b0);
        for (int unsigned i = 0; i < 8; i++)
          for (int unsigned c = 0; c < CPB; c++) ml.push_back(m_b[i]);
        for (int unsigned c = 0; c < CPB; c++) ml.push_back(1'b1);
      end
      if (write_enable && !m_pre_full) mq.push_back(data[7:0]);
      m_took = (ml.size() != 0);
      m_txd  = m_took ? ml.pop_front() : 1'b1;
      m_busy = m_took || (mq.size() != 0);
      m_full = (mq.size() == DEPTH);
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    checks++;
    if (txd !== m_txd) begin errors++; $display("FAIL txd: got %b want %b at %0t", txd, m_txd, $time); end
    checks++;
    if (tx_busy !== m_busy) begin errors++; $display("FAIL tx_busy: got %b want %b at %0t", tx_busy, m_busy, $time); end
    checks++;
    if (tx_full !== m_full) begin errors++; $display("FAIL tx_full: got %b want %b at %0t", tx_full, m_full, $time); end
    checks++;
    if (overflow !== m_ovf) begin errors++; $display("FAIL overflow: got %b want %b at %0t", overflow, m_ovf, $time); end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one write for exactly one sampling edge; returns 1 time unit after it.
  task automatic wr(input logic [31:0] d);
    write_enable = 1'b1;
    data = d;
    @(posedge clk); #1;
    write_enable = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    while (tx_busy !== 1'b0 && n < 2000) begin @(posedge clk); #1; n++; end
    if (n >= 2000) begin
      checks++; errors++;
      $display("FAIL wait_idle: tx_busy still %b after %0d cycles", tx_busy, n);
    end
  endtask

  // Capture one frame as 10 line levels sampled mid-bit (start first).
  task automatic capture(input string name, input logic [9:0] exp);
    logic [9:0]  bits = '1;
    int unsigned n = 0;
    @(negedge clk);
    while (txd !== 1'b0 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL %s: no start bit within %0d cycles", name, n);
    end else begin
      repeat (CPB / 2) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
        bits[i] = txd;
        repeat (CPB) @(negedge clk);
      end
      chk(name, {22'd0, bits}, {22'd0, exp});
    end
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_txd", {31'd0, txd}, 32'd1);
    chk("rst_busy", {31'd0, tx_busy}, 32'd0);
    chk("rst_full", {31'd0, tx_full}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // Single byte 0x55, start latency of one edge, then full frame.
    wr(32'h12345655);
    chk("lat_pre", {31'd0, txd}, 32'd1);
    @(posedge clk); #1;
    chk("lat_start", {31'd0, txd}, 32'd0);
    capture("frame_55", 10'b1010101010);
    chk("busy_after_55", {31'd0, tx_busy}, 32'd0);

    // Upper word bits ignored.
    wr(32'hFFFFFFA5);
    capture("frame_a5", 10'b1101001010);
    wait_idle();

    // Five back-to-back bytes fill the FIFO; a sixth is dropped.
    for (int unsigned i = 1; i <= 5; i++) wr(i);
    chk("full_after_5", {31'd0, tx_full}, 32'd1);
    chk("ovf_before", {31'd0, overflow}, 32'd0);
    wr(32'h000000EE);
    chk("ovf_set", {31'd0, overflow}, 32'd1);
    wait_idle();
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);

    // Reset during data bit 3 aborts the frame immediately.
    wr(32'h000000C3);
    idle(18);
    #1 reset = 1'b0;
    #1;
    chk("abort_txd", {31'd0, txd}, 32'd1);
    chk("abort_busy", {31'd0, tx_busy}, 32'd0);
    chk("abort_ovf", {31'd0, overflow}, 32'd0);
    chk("abort_full", {31'd0, tx_full}, 32'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    wr(32'h0000003C);
    capture("frame_3c", 10'b1001111000);
    wait_idle();

    // Writes on the edges where the FSM pops: first with the FIFO full,
    // then with three entries queued.
    for (int unsigned i = 0; i < 5; i++) wr(32'h10 + i);
    idle(36);
    wr(32'h00000077);
    chk("popfull_ovf", {31'd0, overflow}, 32'd1);
    chk("popfull_full", {31'd0, tx_full}, 32'd0);
    idle(39);
    wr(32'h00000088);
    chk("pop3_full", {31'd0, tx_full}, 32'd0);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
